// File: rtl/integral_window_buffer.sv
// integral_window_buffer: serialises whole integral-image windows into a circular RAM and replays them as parallel windows in FIFO order.
module integral_window_buffer #(
    parameter int DATA_WIDTH    = 12,
    parameter int WIN_W         = 3,
    parameter int WIN_H         = 3,
    parameter int DEPTH_WINDOWS = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                                    clk_fpga,
    input  logic                                    reset_fpga,
    input  logic [DATA_WIDTH*WIN_W*WIN_H-1:0]       i_window,
    input  logic                                    i_valid,
    output logic                                    o_ready,
    output logic [DATA_WIDTH*WIN_W*WIN_H-1:0]       o_window,
    output logic                                    o_valid,
    input  logic                                    i_ready,
    output logic [$clog2(DEPTH_WINDOWS+1)-1:0]      o_windows_stored,
    output logic [CNT_WIDTH-1:0]                    o_drop_count
);
    localparam int N     = WIN_W * WIN_H;
    localparam int WORDS = DEPTH_WINDOWS * N;
    localparam int AW    = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int SW    = $clog2(DEPTH_WINDOWS + 1);
    localparam int KW    = $clog2(N + 1);
    localparam logic [AW-1:0] LAST_BASE = AW'((DEPTH_WINDOWS - 1) * N);
    localparam logic [AW-1:0] STEP      = AW'(N);
    localparam logic [SW-1:0] FULL      = SW'(DEPTH_WINDOWS);
    localparam logic [KW-1:0] LAST_K    = KW'(N - 1);
    localparam logic [KW-1:0] NK        = KW'(N);

    typedef enum logic {W_IDLE, W_SHIFT} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_PRESENT} rstate_t;

    logic [DATA_WIDTH-1:0]   mem [WORDS];
    wstate_t                 ws_q, ws_d;
    rstate_t                 rs_q, rs_d;
    logic [N*DATA_WIDTH-1:0] shadow_q, asm_q;
    logic [KW-1:0]           wk_q, wk_d, rk_q, rk_d, ck_q;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
    logic [SW-1:0]           res_q, res_d, com_q, com_d, sto_q, sto_d;
    logic [CNT_WIDTH-1:0]    drop_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    rv_q;
    logic                    accept, commit, fetch, rel, rd_en, last_cap;

    assign o_ready  = !reset_fpga && ws_q == W_IDLE && res_q < FULL;
    assign accept   = i_valid && o_ready;
    assign commit   = ws_q == W_SHIFT && wk_q == LAST_K;
    assign fetch    = rs_q == R_IDLE && |com_q;
    assign rel      = rs_q == R_PRESENT && i_ready;
    // word 0 is read on the same edge that leaves R_IDLE, saving a cycle of latency
    assign rd_en    = fetch || (rs_q == R_FETCH && rk_q < NK);
    assign rd_addr  = rd_ptr_q + (fetch ? '0 : AW'(rk_q));
    assign last_cap = rv_q && ck_q == LAST_K;

    assign o_window         = asm_q;
    assign o_valid          = rs_q == R_PRESENT;
    assign o_windows_stored = sto_q;
    assign o_drop_count     = drop_q;

    always_comb begin
        ws_d     = ws_q;
        wk_d     = wk_q;
        wr_ptr_d = wr_ptr_q;
        rs_d     = rs_q;
        rk_d     = rk_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            ws_d = W_SHIFT;
            wk_d = '0;
        end else if (ws_q == W_SHIFT) begin
            wk_d = wk_q + 1'b1;
            if (commit) begin
                ws_d     = W_IDLE;
                wr_ptr_d = wr_ptr_q == LAST_BASE ? '0 : wr_ptr_q + STEP;
            end
        end
        if (fetch) begin
            rs_d = R_FETCH;
            rk_d = KW'(1);
        end else if (rs_q == R_FETCH) begin
            rk_d = rd_en ? rk_q + 1'b1 : rk_q;
            if (last_cap) begin
                rs_d     = R_PRESENT;
                rd_ptr_d = rd_ptr_q == LAST_BASE ? '0 : rd_ptr_q + STEP;
            end
        end else if (rel) begin
            rs_d = R_IDLE;
        end
        res_d = res_q + SW'(accept) - SW'(rel);
        com_d = com_q + SW'(commit) - SW'(fetch);
        sto_d = sto_q + SW'(commit) - SW'(rel);
    end

    always_ff @(posedge clk_fpga) begin
        if (ws_q == W_SHIFT) mem[wr_ptr_q + AW'(wk_q)] <= shadow_q[wk_q*DATA_WIDTH +: DATA_WIDTH];
        if (rd_en) dout_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            ws_q     <= W_IDLE;
            rs_q     <= R_IDLE;
            wk_q     <= '0;
            rk_q     <= '0;
            ck_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            res_q    <= '0;
            com_q    <= '0;
            sto_q    <= '0;
            drop_q   <= '0;
            rv_q     <= 1'b0;
            shadow_q <= '0;
            asm_q    <= '0;
        end else begin
            ws_q     <= ws_d;
            rs_q     <= rs_d;
            wk_q     <= wk_d;
            rk_q     <= rk_d;
            ck_q     <= fetch ? '0 : rk_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            res_q    <= res_d;
            com_q    <= com_d;
            sto_q    <= sto_d;
            rv_q     <= rd_en;
            if (accept) shadow_q <= i_window;
            if (rv_q) asm_q[ck_q*DATA_WIDTH +: DATA_WIDTH] <= dout_q;
            if (i_valid && !o_ready && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_integral_window_buffer.sv
// tb_integral_window_buffer: scoreboard plus table-driven and hand-written sequences for integral_window_buffer.
module tb_integral_window_buffer;
    localparam int DW = 12;
    localparam int N  = 9;
    localparam int WB = DW * N;

    typedef struct {
        logic [WB-1:0] win;
        logic [DW-1:0] exp_e0;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, vld, rdy_in, rst2, vld2;
    logic [WB-1:0] win;
    logic          o_ready, o_valid, o_ready2, o_valid2;
    logic [WB-1:0] owin, owin2;
    logic [2:0]    stored, stored2;
    logic [7:0]    drop;
    logic [3:0]    drop2;

    int            checks = 0;
    int            errors = 0;
    logic [WB-1:0] exp_q[$];
    logic [DW-1:0] e0_log[$];
    bit            sb_on = 1'b0;
    int            recv = 0;
    vec_t          tbl[10];

    always #5 clk = ~clk;

    integral_window_buffer dut (
        .clk_fpga(clk), .reset_fpga(rst), .i_window(win), .i_valid(vld), .o_ready(o_ready),
        .o_window(owin), .o_valid(o_valid), .i_ready(rdy_in), .o_windows_stored(stored), .o_drop_count(drop)
    );

    integral_window_buffer #(.CNT_WIDTH(4)) dut2 (
        .clk_fpga(clk), .reset_fpga(rst2), .i_window(win), .i_valid(vld2), .o_ready(o_ready2),
        .o_window(owin2), .o_valid(o_valid2), .i_ready(1'b0), .o_windows_stored(stored2), .o_drop_count(drop2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // accepted offers feed the queue; released windows are popped and compared
    always @(negedge clk) begin
        if (sb_on) begin
            if (vld && o_ready) exp_q.push_back(win);
            if (o_valid && rdy_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected none", owin);
                end else begin
                    chk("sb_window", owin, exp_q.pop_front());
                end
                recv++;
                e0_log.push_back(owin[DW-1:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WB-1:0] mkwin(input int base, input int stride);
        logic [WB-1:0] w;
        for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'(base + stride * k);
        return w;
    endfunction

    task automatic offer(input logic [WB-1:0] w, input bit second);
        int t = 0;
        while (!(second ? o_ready2 : o_ready) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) timeout("offer_ready");
        win = w;
        if (second) vld2 = 1'b1;
        else vld = 1'b1;
        step();
        vld  = 1'b0;
        vld2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat, mism, t, r0;
        logic [WB-1:0] ref_w;
        rst = 1'b1; rst2 = 1'b1; vld = 1'b0; vld2 = 1'b0; rdy_in = 1'b0; win = '0;
        step();
        step();
        chk("rst_o_ready", o_ready, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_window", owin, 0);
        chk("rst_stored", stored, 0);
        chk("rst_drop", drop, 0);
        rst = 1'b0;
        rst2 = 1'b0;
        #1;
        chk("post_rst_o_ready", o_ready, 1);

        // single window latency
        sb_on = 1'b1;
        rdy_in = 1'b1;
        offer(mkwin(100, 1), 1'b0);
        lat = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (i == 8) begin
                chk("single_ready_busy", o_ready, 0);
                chk("single_stored_pre", stored, 0);
            end
            if (i == 9) begin
                chk("single_ready_back", o_ready, 1);
                chk("single_stored_commit", stored, 1);
            end
            if (o_valid && lat == 0) lat = i;
            if (i == 19) chk("single_stored_present", stored, 1);
            if (i == 20) begin
                chk("single_valid_drop", o_valid, 0);
                chk("single_stored_release", stored, 0);
            end
        end
        chk("single_latency", lat, 19);
        chk("single_recv", recv, 1);

        // fill to full with backpressure, then drop offers
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) offer(mkwin(300 + 20 * i, 1), 1'b0);
        for (int i = 0; i < N; i++) step();
        chk("full_stored", stored, 4);
        chk("full_o_ready", o_ready, 0);
        chk("full_drop_zero", drop, 0);
        win = mkwin(900, 1);
        vld = 1'b1;
        r0 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_ready) r0++;
        end
        vld = 1'b0;
        chk("full_drop_count", drop, 12);
        chk("full_ready_stayed_low", r0, 0);
        chk("full_stored_after", stored, 4);
        chk("full_queue_depth", exp_q.size(), 4);
        chk("full_o_valid", o_valid, 1);

        // backpressure hold then single release
        ref_w = owin;
        mism = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (owin !== ref_w || !o_valid) mism++;
        end
        chk("hold_stable", mism, 0);
        chk("hold_window", ref_w, mkwin(300, 1));
        r0 = recv;
        rdy_in = 1'b1;
        step();
        rdy_in = 1'b0;
        chk("release_valid_low", o_valid, 0);
        chk("release_stored", stored, 3);
        chk("release_ready", o_ready, 1);
        for (int i = 0; i < 15; i++) step();
        chk("release_one_only", recv - r0, 1);
        chk("release_next_valid", o_valid, 1);
        chk("release_stored_hold", stored, 3);
        rdy_in = 1'b1;
        t = 0;
        while ((stored != 0 || exp_q.size() != 0) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) timeout("drain_full");
        chk("drain_stored", stored, 0);

        // order across pointer wrap, table driven
        for (int i = 0; i < 10; i++) begin
            tbl[i].win = mkwin(i, 64);
            tbl[i].exp_e0 = DW'(i);
        end
        recv = 0;
        e0_log.delete();
        for (int i = 0; i < 10; i++) offer(tbl[i].win, 1'b0);
        t = 0;
        while (recv < 10 && t < 300) begin
            step();
            t++;
        end
        if (t >= 300) timeout("order_drain");
        chk("order_count", recv, 10);
        for (int i = 0; i < 10; i++)
            if (i < e0_log.size()) chk("order_e0", e0_log[i], tbl[i].exp_e0);

        // reset in the middle of a write while a window is presented
        rdy_in = 1'b0;
        offer(mkwin(1000, 3), 1'b0);
        t = 0;
        while (!o_valid && t < 40) begin
            step();
            t++;
        end
        if (!o_valid) timeout("mid_present");
        offer(mkwin(2000, 1), 1'b0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        exp_q.delete();
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_window", owin, 0);
        chk("mid_rst_stored", stored, 0);
        chk("mid_rst_drop", drop, 0);
        chk("mid_rst_ready", o_ready, 0);
        rst = 1'b0;
        recv = 0;
        e0_log.delete();
        rdy_in = 1'b1;
        offer(mkwin(3000, 1), 1'b0);
        t = 0;
        while (recv < 1 && t < 40) begin
            step();
            t++;
        end
        if (recv < 1) timeout("mid_after_out");
        for (int i = 0; i < 15; i++) step();
        chk("mid_after_count", recv, 1);
        if (e0_log.size() > 0) chk("mid_after_e0", e0_log[0], 3000);
        chk("mid_after_stored", stored, 0);

        // drop counter saturation on the narrow-counter instance
        for (int i = 0; i < 4; i++) offer(mkwin(50 * i, 1), 1'b1);
        for (int i = 0; i < N; i++) step();
        chk("sat_stored", stored2, 4);
        vld2 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("sat_drop_mid", drop2, 10);
        for (int i = 0; i < 10; i++) step();
        vld2 = 1'b0;
        chk("sat_drop_final", drop2, 15);
        chk("sat_ready", o_ready2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
